// File: rtl/i2c_burst_reader.sv
// Burst EEPROM reader: drives an I2C byte-command master and packs the
// returned bytes little-endian into BPW-byte words on a valid/ready port.
module i2c_burst_reader #(
    parameter logic [6:0] SADR    = 7'b1010011,
    parameter int         BPW     = 32,
    parameter int         TIMEOUT = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       offset,
    input  logic [8:0]       length,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       cmd_op,
    output logic             cmd_fun,
    output logic [6:0]       cmd_addr,
    output logic [7:0]       cmd_wdata,
    output logic             cmd_val,
    input  logic             cmd_rdy,
    input  logic [7:0]       rsp_data,
    input  logic             rsp_val,
    output logic             rsp_rdy,
    output logic [8*BPW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [5:0]       out_nbytes
);
    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_INIT  = 3'd1;
    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_STOP  = 3'd5;

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [5:0]    BPW_LAST = 6'(BPW - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_I, S_INIT_W, S_STW_I, S_STW_W,
        S_WOFS_I, S_WOFS_W, S_STR_I, S_STR_W,
        S_RD_I, S_RD_W, S_STOP_I, S_STOP_W, S_FIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_ofs;
    logic [8:0]       r_len;
    logic [8:0]       r_cnt;
    logic [5:0]       r_wcnt;
    logic [TW-1:0]    r_wait;
    logic             r_done;
    logic             r_err;
    logic [8*BPW-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;
    logic [5:0]       r_out_nbytes;

    logic [8:0] w_len;
    logic       w_lastb;
    logic       w_out_free;
    logic       w_accept;
    logic       w_stall;
    logic       w_issue;
    logic       w_tmo;

    assign w_len      = (length > 9'd256) ? 9'd256 : length;
    assign w_lastb    = (r_cnt == r_len - 9'd1);
    assign w_out_free = !r_out_valid || out_ready;
    assign w_accept   = r_out_valid && out_ready;
    // a full word still pending blocks the next READ
    assign w_stall    = (r_state == S_RD_I) && r_out_valid;

    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign err        = r_err;
    assign cmd_addr   = SADR;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign out_last   = r_out_last;
    assign out_nbytes = r_out_nbytes;

    always_comb begin
        w_next    = r_state;
        cmd_op    = OP_NOP;
        cmd_fun   = 1'b0;
        cmd_wdata = 8'd0;
        w_issue   = 1'b0;
        rsp_rdy   = 1'b0;
        unique case (r_state)
            S_INIT_I: begin
                w_issue = 1'b1;
                cmd_op  = OP_INIT;
            end
            S_STW_I: begin
                w_issue = 1'b1;
                cmd_op  = OP_START;
                cmd_fun = 1'b1;
            end
            S_WOFS_I: begin
                w_issue   = 1'b1;
                cmd_op    = OP_WRITE;
                cmd_wdata = r_ofs;
            end
            S_STR_I: begin
                w_issue = 1'b1;
                cmd_op  = OP_START;
            end
            S_RD_I: begin
                w_issue = 1'b1;
                cmd_op  = OP_READ;
                cmd_fun = w_lastb;
            end
            S_STOP_I: begin
                w_issue = 1'b1;
                cmd_op  = OP_STOP;
            end
            S_INIT_W, S_STW_W, S_WOFS_W,
            S_STR_W, S_RD_W, S_STOP_W: rsp_rdy = 1'b1;
            default: ;
        endcase
        cmd_val = w_issue && !w_stall;
        unique case (r_state)
            S_IDLE:   if (start && w_len != 9'd0) w_next = S_INIT_I;
            S_INIT_I: if (cmd_val && cmd_rdy) w_next = S_INIT_W;
            S_INIT_W: if (rsp_val) w_next = S_STW_I;
            S_STW_I:  if (cmd_val && cmd_rdy) w_next = S_STW_W;
            S_STW_W:  if (rsp_val) w_next = S_WOFS_I;
            S_WOFS_I: if (cmd_val && cmd_rdy) w_next = S_WOFS_W;
            S_WOFS_W: if (rsp_val) w_next = S_STR_I;
            S_STR_I:  if (cmd_val && cmd_rdy) w_next = S_STR_W;
            S_STR_W:  if (rsp_val) w_next = S_RD_I;
            S_RD_I:   if (cmd_val && cmd_rdy) w_next = S_RD_W;
            S_RD_W:   if (rsp_val) w_next = w_lastb ? S_STOP_I : S_RD_I;
            S_STOP_I: if (cmd_val && cmd_rdy) w_next = S_STOP_W;
            S_STOP_W: if (rsp_val) w_next = w_out_free ? S_IDLE : S_FIN;
            S_FIN:    if (w_out_free) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        w_tmo = (w_issue || rsp_rdy) && !w_stall &&
                (w_next == r_state) && (r_wait == TMO_LAST);
        if (w_tmo) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ofs        <= '0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_wcnt       <= '0;
            r_wait       <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_nbytes <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            if (w_next != r_state || w_stall) r_wait <= '0;
            else r_wait <= r_wait + TW'(1);
            if (r_state == S_IDLE && start) begin
                r_ofs  <= offset;
                r_len  <= w_len;
                r_cnt  <= '0;
                r_wcnt <= '0;
                r_done <= (w_len == 9'd0);
            end
            if (w_accept) begin
                r_out_data   <= '0;
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_out_nbytes <= '0;
            end
            if (r_state == S_RD_W && rsp_val) begin
                for (int b = 0; b < BPW; b++)
                    if (r_wcnt == 6'(b)) r_out_data[8*b +: 8] <= rsp_data;
                r_cnt <= r_cnt + 9'd1;
                if (w_lastb || r_wcnt == BPW_LAST) begin
                    r_out_valid  <= 1'b1;
                    r_out_last   <= w_lastb;
                    r_out_nbytes <= r_wcnt + 6'd1;
                    r_wcnt       <= '0;
                end else begin
                    r_wcnt <= r_wcnt + 6'd1;
                end
            end
            if ((r_state == S_STOP_W && rsp_val && w_out_free) ||
                (r_state == S_FIN && w_out_free))
                r_done <= 1'b1;
            if (w_tmo) begin
                r_done       <= 1'b1;
                r_err        <= 1'b1;
                r_out_data   <= '0;
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_out_nbytes <= '0;
            end
        end
    end
endmodule

// File: tb/tb_i2c_burst_reader.sv
// Bench for i2c_burst_reader: scripted I2C responder plus scoreboards for
// the command stream, the output words and the done/err pulses.
module tb_i2c_burst_reader;
    localparam logic [6:0] SADR     = 7'b1010011;
    localparam logic [2:0] OP_INIT  = 3'd1;
    localparam logic [2:0] OP_START = 3'd2;
    localparam logic [2:0] OP_WRITE = 3'd3;
    localparam logic [2:0] OP_READ  = 3'd4;
    localparam logic [2:0] OP_STOP  = 3'd5;

    typedef struct packed {
        logic [2:0] op;
        logic       fun;
        logic [7:0] wd;
    } cmd_t;

    typedef struct packed {
        logic [255:0] d;
        logic         last;
        logic [5:0]   nb;
    } word_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [7:0]   offset = '0;
    logic [8:0]   length = '0;
    logic         busy, done, err;
    logic [2:0]   cmd_op;
    logic         cmd_fun;
    logic [6:0]   cmd_addr;
    logic [7:0]   cmd_wdata;
    logic         cmd_val;
    logic         cmd_rdy = 1'b1;
    logic [7:0]   rsp_data = '0;
    logic         rsp_val = 1'b0;
    logic         rsp_rdy;
    logic [255:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;
    logic [5:0]   out_nbytes;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_rd_edge = 0;
    int rd_limit = 1000000;
    logic [7:0] mem [256];

    cmd_t  cq[$];
    word_t wq[$];
    logic  dq[$];

    i2c_burst_reader #(.SADR(SADR), .BPW(32), .TIMEOUT(100)) dut (
        .clk(clk), .reset(reset), .start(start),
        .offset(offset), .length(length),
        .busy(busy), .done(done), .err(err),
        .cmd_op(cmd_op), .cmd_fun(cmd_fun), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
        .rsp_data(rsp_data), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_nbytes(out_nbytes)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [263:0] act,
                       input logic [263:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [2:0] op, input logic f,
                                input logic [7:0] w);
        cmd_t c;
        c.op = op;
        c.fun = f;
        c.wd = w;
        return c;
    endfunction

    task automatic push_burst(input logic [7:0] o, input int n);
        word_t w;
        int nb;
        cq.push_back(mk(OP_INIT, 1'b0, 8'd0));
        cq.push_back(mk(OP_START, 1'b1, 8'd0));
        cq.push_back(mk(OP_WRITE, 1'b0, o));
        cq.push_back(mk(OP_START, 1'b0, 8'd0));
        for (int k = 0; k < n; k++)
            cq.push_back(mk(OP_READ, k == n - 1, 8'd0));
        cq.push_back(mk(OP_STOP, 1'b0, 8'd0));
        w = '0;
        nb = 0;
        for (int k = 0; k < n; k++) begin
            w.d[8*nb +: 8] = mem[8'(int'(o) + k)];
            nb++;
            if (nb == 32 || k == n - 1) begin
                w.last = (k == n - 1);
                w.nb = 6'(nb);
                wq.push_back(w);
                w = '0;
                nb = 0;
            end
        end
        dq.push_back(1'b0);
    endtask

    task automatic do_start(input logic [7:0] o, input logic [8:0] l);
        @(posedge clk); #1;
        offset = o;
        length = l;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checks++;
        failures++;
        $display("FAIL %s: done not seen within %0d cycles", nm, lim);
    endtask

    task automatic chk_drained(input string nm);
        chk(nm, 264'(cq.size() + wq.size() + dq.size()), 264'd0);
    endtask

    // responder: answers each accepted command one cycle later
    initial begin : responder
        logic       cmd_pend, rsp_pend;
        logic [2:0] c_op;
        logic [7:0] c_wd, ptr;
        int         rd_cnt;
        cmd_pend = 1'b0;
        rsp_pend = 1'b0;
        c_op = '0;
        c_wd = '0;
        ptr = '0;
        rd_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rsp_val = 1'b0;
                cmd_pend = 1'b0;
                rsp_pend = 1'b0;
                rd_cnt = 0;
            end else begin
                if (rsp_pend) rsp_val = 1'b0;
                if (cmd_pend) begin
                    rsp_data = 8'd0;
                    case (c_op)
                        OP_WRITE: begin
                            ptr = c_wd;
                            rsp_val = 1'b1;
                        end
                        OP_READ: begin
                            if (rd_cnt < rd_limit) begin
                                rsp_data = mem[ptr];
                                ptr = ptr + 8'd1;
                                rsp_val = 1'b1;
                            end
                            rd_cnt++;
                        end
                        OP_INIT: begin
                            rd_cnt = 0;
                            rsp_val = 1'b1;
                        end
                        default: rsp_val = 1'b1;
                    endcase
                end
                cmd_pend = cmd_val && cmd_rdy;
                if (cmd_pend) begin
                    c_op = cmd_op;
                    c_wd = cmd_wdata;
                end
                rsp_pend = rsp_val && rsp_rdy;
            end
        end
    end

    initial begin : monitor
        cmd_t  ec;
        word_t ew;
        logic  ee;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (cmd_val && cmd_rdy) begin
                    if (cq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL cmd_unexpected: got op=%0d fun=%0d wdata=%h required none",
                                 cmd_op, cmd_fun, cmd_wdata);
                    end else begin
                        ec = cq.pop_front();
                        chk("cmd", {cmd_addr, cmd_op, cmd_fun, cmd_wdata},
                            {SADR, ec});
                    end
                    if (cmd_op == OP_READ) last_rd_edge = cyc + 1;
                end
                if (out_valid && out_ready) begin
                    if (wq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL word_unexpected: got nbytes=%0d last=%0d required none",
                                 out_nbytes, out_last);
                    end else begin
                        ew = wq.pop_front();
                        chk("word", {out_data, out_last, out_nbytes}, ew);
                    end
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL done_unexpected: got done err=%0d required none", err);
                    end else begin
                        ee = dq.pop_front();
                        chk("done_err", err, ee);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [262:0] cap;
        int bad_rd, bad_st, seen;

        for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hA5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            {busy, done, err, cmd_val, rsp_rdy, out_valid, out_last, out_nbytes, out_data},
            '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 38 bytes from 0x00: one full word then a 6-byte tail
        push_burst(8'h00, 38);
        do_start(8'h00, 9'd38);
        wait_done("t38_done", 1000);
        chk_drained("t38_drained");

        // full 256-byte burst, bytes equal to their address
        for (int a = 0; a < 256; a++) mem[a] = 8'(a);
        push_burst(8'h00, 256);
        do_start(8'h00, 9'd256);
        wait_done("t256_done", 3000);
        chk_drained("t256_drained");

        // length above 256 is clamped
        push_burst(8'h80, 256);
        do_start(8'h80, 9'd400);
        wait_done("tclamp_done", 3000);
        chk_drained("tclamp_drained");

        // downstream back-pressure after word 0
        push_burst(8'h40, 40);
        @(posedge clk); #1;
        out_ready = 1'b0;
        do_start(8'h40, 9'd40);
        seen = 0;
        for (int i = 0; i < 500 && seen == 0; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("bp_word0_seen", 264'(seen), 264'd1);
        cap = {out_data, out_last, out_nbytes};
        bad_rd = 0;
        bad_st = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cmd_val && cmd_op == OP_READ) bad_rd++;
            if ({out_valid, out_data, out_last, out_nbytes} !== {1'b1, cap}) bad_st++;
        end
        chk("bp_no_read", 264'(bad_rd), 264'd0);
        chk("bp_stable", 264'(bad_st), 264'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done("bp_done", 1000);
        chk_drained("bp_drained");

        // start while busy is ignored
        push_burst(8'h05, 3);
        do_start(8'h05, 9'd3);
        chk("busy_high", busy, 1'b1);
        do_start(8'h40, 9'd7);
        wait_done("ign_done", 500);
        chk_drained("ign_drained");

        // zero length: done on the next cycle, nothing issued
        dq.push_back(1'b0);
        @(posedge clk); #1;
        offset = 8'h00;
        length = 9'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("len0_done", {done, err, busy, cmd_val}, 4'b1000);
        @(posedge clk); #1;
        chk("len0_pulse", {done, busy}, 2'b00);
        chk_drained("len0_drained");

        // responder falls silent after five READs
        rd_limit = 5;
        cq.push_back(mk(OP_INIT, 1'b0, 8'd0));
        cq.push_back(mk(OP_START, 1'b1, 8'd0));
        cq.push_back(mk(OP_WRITE, 1'b0, 8'h30));
        cq.push_back(mk(OP_START, 1'b0, 8'd0));
        for (int k = 0; k < 6; k++) cq.push_back(mk(OP_READ, 1'b0, 8'd0));
        dq.push_back(1'b1);
        do_start(8'h30, 9'd10);
        wait_done("tmo_done", 1000);
        chk("tmo_delay", 264'(cyc - last_rd_edge), 264'd100);
        chk("tmo_outs", {out_valid, busy}, 2'b00);
        repeat (20) @(negedge clk);
        chk_drained("tmo_drained");
        rd_limit = 1000000;

        // reset in the middle of the READ phase
        do_start(8'h00, 9'd20);
        push_burst(8'h00, 20);
        seen = 0;
        for (int i = 0; i < 200 && seen == 0; i++) begin
            @(negedge clk);
            if (cmd_val && cmd_op == OP_READ) seen = 1;
        end
        chk("rst_rd_reached", 264'(seen), 264'd1);
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("rst_outputs",
            {busy, done, err, cmd_val, rsp_rdy, out_valid, out_last, out_nbytes, out_data},
            '0);
        cq.delete();
        wq.delete();
        dq.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push_burst(8'h10, 4);
        do_start(8'h10, 9'd4);
        wait_done("rst_fresh_done", 500);
        repeat (5) @(negedge clk);
        chk_drained("final_drained");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/i2c_burst_reader.md
I2C_BURST_READER -- requirements
Module: i2c_burst_reader

Interface
REQ-001 SHALL have parameter SADR, default 7'b1010011, the 7-bit I2C slave address.
REQ-002 SHALL have parameter BPW, default 32, the number of bytes per output word (1..32).
REQ-003 SHALL have parameter TIMEOUT, default 1000000, the maximum clk cycles to wait for any single response.
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin a burst.
REQ-007 offset  in  8  first EEPROM byte address, sampled when start is accepted.
REQ-008 length  in  9  byte count, sampled when start is accepted; 0 means none, values above 256 are clamped to 256.
REQ-009 busy  out  1  high from the accepted start until the done pulse.
REQ-010 done  out  1  one-cycle pulse at burst end.
REQ-011 err  out  1  valid with done; 1 when the burst was aborted by timeout.
REQ-012 cmd_op  out  3  OP_* code per i2c_master_defines.v.
REQ-013 cmd_fun  out  1  sub-function: START 1=write/0=read; READ 1=NACK.
REQ-014 cmd_addr  out  7  always SADR.
REQ-015 cmd_wdata  out  8  write byte.
REQ-016 cmd_val  out  1  command valid.
REQ-017 cmd_rdy  in  1  command accepted.
REQ-018 rsp_data  in  8  read byte.
REQ-019 rsp_val  in  1  response valid.
REQ-020 rsp_rdy  out  1  response ready.
REQ-021 out_data  out  8*BPW  packed bytes.
REQ-022 out_valid  out  1  output word valid.
REQ-023 out_ready  in  1  downstream ready.
REQ-024 out_last  out  1  marks the final word of a burst.
REQ-025 out_nbytes  out  6  count of valid bytes in out_data (1..BPW).

Function
REQ-026 SHALL step through the states IDLE, INIT, START_W, WR_OFS, START_R, RD, STOP, FIN, with each command state split into ISSUE and WAIT.
- ISSUE: cmd_val=1; moves to WAIT on the cycle with cmd_val&cmd_rdy.
- WAIT: rsp_rdy=1; advances on the cycle with rsp_val&rsp_rdy.
REQ-027 Command order SHALL be:
- INIT
- START fun=1
- WRITE of offset, fun=0
- START fun=0
- N× READ, with fun=1 only on byte N-1 and fun=0 otherwise
- STOP, then FIN.
REQ-028 SHALL hold cmd_op, cmd_fun and cmd_wdata stable while cmd_val=1; cmd_wdata SHALL be 0 whenever the op is not WRITE.
REQ-029 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-030 When length is 0, the block SHALL pulse done with err=0 on the cycle after start, with no commands issued and no output word.
REQ-031 Byte k of the burst SHALL be written to out_data bits [8*(k mod BPW)+7 : 8*(k mod BPW)] (little-endian packing).
REQ-032 A word SHALL be presented when it holds BPW bytes or when it holds the final byte; unused bytes of a partial word SHALL be 0.
REQ-033 out_valid SHALL stay asserted, with out_data, out_last and out_nbytes stable, until the cycle with out_valid&out_ready.
REQ-034 Only one output word SHALL be buffered: the next READ ISSUE SHALL stall (cmd_val=0) while a full word is pending and not yet accepted.
REQ-035 done SHALL pulse in the cycle after both conditions hold: the STOP response is received and the last word is accepted; the FSM SHALL then return to IDLE.
REQ-036 A wait counter SHALL clear on entry to each ISSUE and each WAIT state; reaching TIMEOUT in either state SHALL force the FSM to IDLE.
- done=1 and err=1 in that cycle.
- Any partial word is discarded (out_valid=0).
- No STOP is issued.
REQ-037 The internal byte counter SHALL be 9 bits wide; a length of 256 SHALL complete without wrap-around.

Reset
REQ-038 While reset=1, the block SHALL force IDLE and drive all of the following to 0: busy, done, err, cmd_val, rsp_rdy, out_valid, out_last, out_nbytes, out_data.
REQ-039 Reset asserted mid-burst SHALL abort immediately with no done pulse; the first start after reset deasserts SHALL begin a fresh burst.

Verification
REQ-040 offset=0x00, length=38, BPW=32, responder always ready, out_ready=1 -> command sequence INIT, START/1, WRITE 0x00, START/0, 37× READ/0, READ/1, STOP; two words: nbytes=32 last=0, then nbytes=6 last=1 with upper bytes 0; done=1, err=0.
REQ-041 length=256, bytes equal to their address -> eight words with byte k = k, the last word with last=1 and nbytes=32; no counter wrap.
REQ-042 length=40 with out_ready held 0 for 500 cycles after word 0 -> no READ cmd_val during the hold, word 0 stable throughout, complete data after release.
REQ-043 responder stops answering after READ 5, TIMEOUT=100 -> done=1 and err=1 exactly 100 cycles into WAIT; out_valid=0; no STOP issued.
REQ-044 start pulsed during busy, and a length=0 burst -> the first is ignored; the second gives done one cycle after start with no commands.
REQ-045 reset asserted during RD -> all outputs 0 at once; a subsequent burst with offset=0x10, length=4 gives the correct single word with nbytes=4.
